// File: rtl/alu_issue_ctrl.sv
// Issue/writeback front-end for the 64-bit combinational ALU: it latches a request, holds the
// ALU operands for an op-dependent number of cycles and then keeps the response. Optional macro: ALU_ISSUE_DIV0_CHECK_EN.
module alu_issue_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic [2:0]   ReqOp,
    input  logic [63:0]  ReqA,
    input  logic [63:0]  ReqB,
    output logic [63:0]  AluA,
    output logic [63:0]  AluB,
    output logic         AluCin,
    output logic [3:0]   AluCtrl,
    input  logic [127:0] AluResult,
    input  logic         AluZero,
    input  logic         AluOverflow,
    output logic         RspValid,
    input  logic         RspReady,
    output logic [127:0] RspResult,
    output logic         RspZero,
    output logic         RspOverflow,
    output logic         RspDivByZero
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [63:0]        r_a;
    logic [63:0]        r_b;
    logic               r_rsp_valid;
    logic [127:0]       r_rsp_result;
    logic               r_rsp_zero;
    logic               r_rsp_ovf;
    logic               r_rsp_dbz;
    logic               w_accept;
    logic               w_capture;
    logic               w_div0_short;
    logic               w_op_legal;
    logic               w_op_addsub;

    // Counter is loaded with L-1 so the capture edge is the one where it reads zero.
    function automatic logic [CNT_W-1:0] f_lat_m1(input logic [2:0] op);
        case (op)
            OP_MUL:  return CNT_W'(MUL_LAT - 1);
            OP_DIV:  return CNT_W'(DIV_LAT - 1);
            default: return '0;
        endcase
    endfunction

`ifdef ALU_ISSUE_DIV0_CHECK_EN
    assign w_div0_short = (ReqOp == OP_DIV) && (ReqB == 64'd0);
`else
    assign w_div0_short = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ReqValid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_div0_short ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (RspReady) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_op_legal  = (r_op <= OP_AND);
    assign w_op_addsub = (r_op == OP_ADD) || (r_op == OP_SUB);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_dbz    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= ReqOp;
                r_a   <= ReqA;
                r_b   <= ReqB;
                r_cnt <= f_lat_m1(ReqOp);
            end else if (r_state == S_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_capture) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= w_op_legal ? AluResult : 128'd0;
                r_rsp_zero   <= w_op_legal ? AluZero : 1'b1;
                // The ALU overflow output is only meaningful for add/sub.
                r_rsp_ovf    <= w_op_addsub ? AluOverflow : 1'b0;
                r_rsp_dbz    <= 1'b0;
            end else if (w_accept && w_div0_short) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= '1;
                r_rsp_zero   <= 1'b0;
                r_rsp_ovf    <= 1'b0;
                r_rsp_dbz    <= 1'b1;
            end else if (r_rsp_valid && RspReady) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    always_comb begin
        AluCtrl = 4'b1111;
        if (r_state == S_EXEC) begin
            case (r_op)
                OP_ADD:  AluCtrl = 4'b0010;
                OP_SUB:  AluCtrl = 4'b0110;
                OP_MUL:  AluCtrl = 4'b0011;
                OP_DIV:  AluCtrl = 4'b0001;
                OP_SLT:  AluCtrl = 4'b0111;
                OP_AND:  AluCtrl = 4'b0000;
                default: AluCtrl = 4'b1111;
            endcase
        end
    end

    assign AluA         = (r_state == S_EXEC) ? r_a : 64'd0;
    assign AluB         = (r_state == S_EXEC) ? r_b : 64'd0;
    assign AluCin       = 1'b0;
    assign ReqReady     = (r_state == S_IDLE) && !reset;
    assign RspValid     = r_rsp_valid;
    assign RspResult    = r_rsp_result;
    assign RspZero      = r_rsp_zero;
    assign RspOverflow  = r_rsp_ovf;
    assign RspDivByZero = r_rsp_dbz;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU stub, a reference model of expected
// responses, a driver issuing directed and random requests and a monitor that pops and compares.
module tb_alu_issue_ctrl;
    localparam int  MUL_LAT = 2;
    localparam int  DIV_LAT = 4;
    localparam time PERIOD  = 10;
    localparam time HALF    = 5;

    logic         clk;
    logic         reset;
    logic         ReqValid;
    logic         ReqReady;
    logic [2:0]   ReqOp;
    logic [63:0]  ReqA;
    logic [63:0]  ReqB;
    logic [63:0]  AluA;
    logic [63:0]  AluB;
    logic         AluCin;
    logic [3:0]   AluCtrl;
    logic [127:0] AluResult;
    logic         AluZero;
    logic         AluOverflow;
    logic         RspValid;
    logic         RspReady;
    logic [127:0] RspResult;
    logic         RspZero;
    logic         RspOverflow;
    logic         RspDivByZero;

    alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
        .AluA(AluA), .AluB(AluB), .AluCin(AluCin), .AluCtrl(AluCtrl),
        .AluResult(AluResult), .AluZero(AluZero), .AluOverflow(AluOverflow),
        .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult),
        .RspZero(RspZero), .RspOverflow(RspOverflow), .RspDivByZero(RspDivByZero)
    );

    initial clk = 1'b0;
    always #(HALF) clk = ~clk;

    function automatic logic [127:0] sx(input logic [63:0] v);
        return {{64{v[63]}}, v};
    endfunction

    // Behavioural ALU; overflow reads as 1 for every op except add/sub (a stale value).
    logic [63:0] alu_s64;
    logic [63:0] alu_q64;
    always_comb begin
        AluResult   = '0;
        AluOverflow = 1'b1;
        alu_s64     = '0;
        alu_q64     = '0;
        case (AluCtrl)
            4'b0010: begin
                alu_s64     = AluA + AluB;
                AluResult   = sx(alu_s64);
                AluOverflow = (AluA[63] == AluB[63]) && (alu_s64[63] != AluA[63]);
            end
            4'b0110: begin
                alu_s64     = AluA - AluB;
                AluResult   = sx(alu_s64);
                AluOverflow = (AluA[63] != AluB[63]) && (alu_s64[63] != AluA[63]);
            end
            4'b0011: AluResult = sx(AluA) * sx(AluB);
            4'b0001: begin
                if (AluB == 64'd0) begin
                    AluResult = '1;
                end else begin
                    alu_q64   = $signed(AluA) / $signed(AluB);
                    AluResult = sx(alu_q64);
                end
            end
            4'b0111: AluResult = ($signed(AluA) < $signed(AluB)) ? 128'd1 : 128'd0;
            4'b0000: AluResult = {64'd0, AluA & AluB};
            default: AluResult = '0;
        endcase
        AluZero = (AluResult == 128'd0);
    end

    typedef struct {
        logic [2:0]   op;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] res;
        logic         zero;
        logic         ovf;
        logic         dbz;
        logic [3:0]   ctrl;
        int           lat;
        int           execs;
        time          t_acc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   force_stall = 0;
    bit   idle_bad = 1'b0;

    task automatic check(input string name, input bit ok, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Expected response computed with wide signed arithmetic straight from the op rules.
    function automatic exp_t ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic signed [127:0] wa, wb, full;
        logic [127:0] quo;
        wa = $signed(sx(a));
        wb = $signed(sx(b));
        e.op = op; e.a = a; e.b = b; e.ovf = 1'b0; e.dbz = 1'b0;
        e.lat = 1; e.execs = 1; e.ctrl = 4'b1111; e.res = '0; e.t_acc = 0;
        case (op)
            3'd0: begin full = wa + wb; e.res = sx(full[63:0]); e.ovf = (full != e.res); e.ctrl = 4'b0010; end
            3'd1: begin full = wa - wb; e.res = sx(full[63:0]); e.ovf = (full != e.res); e.ctrl = 4'b0110; end
            3'd2: begin e.res = wa * wb; e.lat = MUL_LAT; e.execs = MUL_LAT; e.ctrl = 4'b0011; end
            3'd3: begin
                e.ctrl = 4'b0001; e.lat = DIV_LAT; e.execs = DIV_LAT;
                if (b == 64'd0) begin
                    e.res = '1;
`ifdef ALU_ISSUE_DIV0_CHECK_EN
                    e.lat = 1; e.execs = 0; e.dbz = 1'b1;
`endif
                end else begin
                    quo = wa / wb;
                    e.res = sx(quo[63:0]);
                end
            end
            3'd4: begin e.res = (wa < wb) ? 128'd1 : 128'd0; e.ctrl = 4'b0111; end
            3'd5: begin e.res = {64'd0, a & b}; e.ctrl = 4'b0000; end
            default: e.res = '0;
        endcase
        e.zero = (e.res == 128'd0);
        return e;
    endfunction

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int waited;
        e = ref_model(op, a, b);
        @(negedge clk);
        ReqValid = 1'b1; ReqOp = op; ReqA = a; ReqB = b;
        waited = 0;
        while (ReqReady !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            check("req_accept_timeout", ReqReady === 1'b1, {127'd0, ReqReady}, 128'd1);
            ReqValid = 1'b0;
        end else begin
            e.t_acc = $time + HALF;
            q.push_back(e);
            @(posedge clk);
            #1;
            ReqValid = 1'b0;
            ReqOp = 3'($urandom_range(0, 7));
            ReqA = {$urandom(), $urandom()};
            ReqB = {$urandom(), $urandom()};
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || RspValid === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", q.size() == 0, 128'(q.size()), 128'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_rsp_result", RspResult === 128'd0, RspResult, 128'd0);
        check("rst_alu_operands", {AluA, AluB} === 128'd0, {AluA, AluB}, 128'd0);
        check("rst_ctrl_flags",
              {ReqReady, RspValid, RspZero, RspOverflow, RspDivByZero, AluCin, AluCtrl} === 10'b0000001111,
              128'({ReqReady, RspValid, RspZero, RspOverflow, RspDivByZero, AluCin, AluCtrl}), 128'h00f);
    endtask

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0: return 64'(signed'($urandom_range(0, 20)) - 10);
            1: return 64'h8000_0000_0000_0000;
            2: return 64'h7fff_ffff_ffff_ffff;
            3: return 64'd0;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Monitor / consumer: tracks EXEC-phase ALU drive, pops and compares each response.
    initial begin : monitor
        exp_t         e;
        bit           in_resp, hold_bad, alu_bad, chk_rdy_next;
        int           exec_cnt, hold_cnt, lat;
        logic [130:0] snap;
        in_resp = 0; hold_bad = 0; alu_bad = 0; chk_rdy_next = 0;
        exec_cnt = 0; hold_cnt = 0;
        forever begin
            @(negedge clk);
            if (chk_rdy_next) begin
                chk_rdy_next = 0;
                check("ready_after_handshake", ReqReady === 1'b1 && RspValid === 1'b0,
                      128'({ReqReady, RspValid}), 128'b10);
            end
            if (q.size() == 0) begin
                exec_cnt = 0;
                alu_bad  = 0;
            end
            if (!reset && q.size() == 0 && RspValid !== 1'b1) begin
                if (AluA !== 64'd0 || AluB !== 64'd0 || AluCtrl !== 4'b1111 || AluCin !== 1'b0) idle_bad = 1'b1;
            end
            if (!reset && q.size() > 0 && RspValid !== 1'b1 && $time > q[0].t_acc) begin
                exec_cnt++;
                if (AluA !== q[0].a || AluB !== q[0].b || AluCtrl !== q[0].ctrl || AluCin !== 1'b0) alu_bad = 1;
            end
            if (!reset && RspValid === 1'b1) begin
                if (!in_resp) begin
                    check("no_spurious_rsp", q.size() != 0, RspResult, 128'd0);
                    if (q.size() != 0) begin
                        e   = q[0];
                        lat = int'(($time - HALF - e.t_acc) / PERIOD);
                        check("latency", lat == e.lat, 128'(lat), 128'(e.lat));
                        check("rsp_result", RspResult === e.res, RspResult, e.res);
                        check("rsp_zero", RspZero === e.zero, 128'(RspZero), 128'(e.zero));
                        check("rsp_overflow", RspOverflow === e.ovf, 128'(RspOverflow), 128'(e.ovf));
                        check("rsp_div_by_zero", RspDivByZero === e.dbz, 128'(RspDivByZero), 128'(e.dbz));
                        check("exec_cycles", exec_cnt == e.execs, 128'(exec_cnt), 128'(e.execs));
                        check("alu_drive_stable", !alu_bad, {AluA, AluB}, {e.a, e.b});
                        snap     = {RspResult, RspZero, RspOverflow, RspDivByZero};
                        in_resp  = 1;
                        hold_bad = (ReqReady !== 1'b0);
                        hold_cnt = (force_stall > 0) ? force_stall : int'($urandom_range(0, 2));
                        force_stall = 0;
                    end
                end else begin
                    if ({RspResult, RspZero, RspOverflow, RspDivByZero} !== snap || ReqReady !== 1'b0) hold_bad = 1;
                end
                RspReady = (hold_cnt == 0);
                if (hold_cnt > 0) hold_cnt--;
                if (RspReady && in_resp) begin
                    check("rsp_hold_stable", !hold_bad, snap[130:3], RspResult);
                    $display("txn op=%0d a=%h b=%h res=%h zero=%b ovf=%b dbz=%b lat=%0d",
                             e.op, e.a, e.b, RspResult, RspZero, RspOverflow, RspDivByZero, lat);
                    void'(q.pop_front());
                    in_resp = 0;
                    chk_rdy_next = 1;
                end
            end else begin
                RspReady = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : driver
        logic [2:0]  op;
        logic [63:0] a, b;
        reset = 1'b1; ReqValid = 1'b0; ReqOp = '0; ReqA = '0; ReqB = '0; RspReady = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clk);
        check("ready_out_of_reset", ReqReady === 1'b1, 128'(ReqReady), 128'd1);

        send(3'd0, 64'd5, 64'd7);
        send(3'd1, 64'h8000_0000_0000_0000, 64'd1);
        send(3'd5, 64'h8000_0000_0000_0000, 64'd1);
        send(3'd2, 64'hffff_ffff_ffff_fffd, 64'd4);
        send(3'd3, 64'd10, 64'd0);
        send(3'd6, 64'd3, 64'd3);
        wait_drain();
        force_stall = 5;
        send(3'd4, 64'hffff_ffff_ffff_ffff, 64'd1);
        wait_drain();

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand64();
            b  = rand64();
            if (op == 3'd3 && $urandom_range(0, 3) == 0) b = 64'd0;
            if (op == 3'd3 && a == 64'h8000_0000_0000_0000 && b == '1) b = 64'd2;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(op, a, b);
        end
        wait_drain();

        // Reset lands in the second EXEC cycle of a DIV; no response may follow.
        send(3'd3, 64'd100, 64'd7);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        send(3'd0, 64'd1, 64'd1);
        wait_drain();
        repeat (3) @(negedge clk);
        check("idle_alu_default", !idle_bad, 128'(idle_bad), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
